// File: rtl/draw_player_anim_if.sv
// VGA timing/pixel bundle passed between the drawing stages.
// Ports: vcount/hcount (11b), vsync, hsync, vblnk, hblnk, rgb (12b).
// Modport "in" is for a stage's upstream side, "out" for its downstream side.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_player_anim.sv
// Animation states shared with the rest of the game logic.
package state_pkg;
    typedef enum logic [2:0] {IDLE, RIGHT1, RIGHT2, LEFT1, LEFT2} State;
endpackage

// Animated player sprite overlay on the VGA stream.
// Latency: every vga_out field is vga_in delayed by exactly 2 clk cycles.
// Backpressure: none; one pixel in and one pixel out per cycle.
// Ports: clk, rst (sync, active-high), vga_in/vga_out (vga_if), xpos/ypos
//   (sprite top-left, latched on vblnk rising edge), move_left/move_right
//   (level requests), state_o (current animation state).
module draw_player_anim
    import state_pkg::*;
#(
    parameter int          SPRITE_W  = 40,
    parameter int          SPRITE_H  = 80,
    parameter logic [11:0] BODY_RGB  = 12'hF0F,
    parameter logic [11:0] EYE_RGB   = 12'h0FF,
    parameter int          FRAME_DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        move_left,
    input  logic        move_right,
    output State        state_o
);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    // Sprite-local column/row boundaries.
    localparam logic [11:0] W8  = 12'(SPRITE_W / 8);
    localparam logic [11:0] W4  = 12'(SPRITE_W / 4);
    localparam logic [11:0] W38 = 12'(3 * SPRITE_W / 8);
    localparam logic [11:0] W58 = 12'(5 * SPRITE_W / 8);
    localparam logic [11:0] W34 = 12'(3 * SPRITE_W / 4);
    localparam logic [11:0] W78 = 12'(7 * SPRITE_W / 8);
    localparam logic [11:0] H8  = 12'(SPRITE_H / 8);
    localparam logic [11:0] H4  = 12'(SPRITE_H / 4);
    localparam logic [11:0] H34 = 12'(3 * SPRITE_H / 4);

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        hsync;
        logic        vblnk;
        logic        hblnk;
        logic [11:0] rgb;
    } pix_t;

    typedef struct packed {
        pix_t        pix;
        logic        in_box;
        logic [11:0] rx;
        logic [11:0] ry;
        State        st;
    } stage1_t;

    logic             vblnk_prev_q;
    logic [11:0]      x_lat_q, x_lat_d, y_lat_q, y_lat_d;
    logic             mv_l_q, mv_l_d, mv_r_q, mv_r_d;
    State             state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    stage1_t          s1_q, s1_d;
    pix_t             s2_q, s2_d;

    logic tick, go_r, go_l;
    logic [12:0] h13, v13, x13, y13;
    logic body, leg_col, eye_col, eye_row;

    // Frame latching and walk FSM
    always_comb begin
        tick    = vga_in.vblnk & ~vblnk_prev_q;
        x_lat_d = tick ? xpos : x_lat_q;
        y_lat_d = tick ? ypos : y_lat_q;
        mv_l_d  = tick ? move_left  : mv_l_q;
        mv_r_d  = tick ? move_right : mv_r_q;
        go_r    = mv_r_d & ~mv_l_d;
        go_l    = mv_l_d & ~mv_r_d;
        state_d = state_q;
        div_d   = div_q;
        if (tick) begin
            if (go_r) begin
                if (state_q != RIGHT1 && state_q != RIGHT2) begin
                    state_d = RIGHT1;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    state_d = (state_q == RIGHT1) ? RIGHT2 : RIGHT1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end else if (go_l) begin
                if (state_q != LEFT1 && state_q != LEFT2) begin
                    state_d = LEFT1;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    state_d = (state_q == LEFT1) ? LEFT2 : LEFT1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end else begin
                state_d = IDLE;
                div_d   = '0;
            end
        end
    end

    // Stage 1: box test in 13 bits so a sprite near the right/bottom edge
    // clips instead of wrapping back onto column/row 0.
    always_comb begin
        h13 = {2'b00, vga_in.hcount};
        v13 = {2'b00, vga_in.vcount};
        x13 = {1'b0, x_lat_q};
        y13 = {1'b0, y_lat_q};
        s1_d.pix.vcount = vga_in.vcount;
        s1_d.pix.hcount = vga_in.hcount;
        s1_d.pix.vsync  = vga_in.vsync;
        s1_d.pix.hsync  = vga_in.hsync;
        s1_d.pix.vblnk  = vga_in.vblnk;
        s1_d.pix.hblnk  = vga_in.hblnk;
        s1_d.pix.rgb    = vga_in.rgb;
        s1_d.in_box = (h13 >= x13) && (h13 < x13 + 13'(SPRITE_W)) &&
                      (v13 >= y13) && (v13 < y13 + 13'(SPRITE_H));
        s1_d.rx = {1'b0, vga_in.hcount} - x_lat_q;
        s1_d.ry = {1'b0, vga_in.vcount} - y_lat_q;
        s1_d.st = state_q;
    end

    // Stage 2: shape lookup; rx/ry are only meaningful when in_box is set.
    always_comb begin
        body    = s1_q.ry < H34;
        eye_row = (s1_q.ry >= H8) && (s1_q.ry < H4);
        case (s1_q.st)
            IDLE: begin
                leg_col = (s1_q.rx < W38) || (s1_q.rx >= W58);
                eye_col = ((s1_q.rx >= W8) && (s1_q.rx < W4)) ||
                          ((s1_q.rx >= W34) && (s1_q.rx < W78));
            end
            RIGHT1, LEFT1: begin
                leg_col = ((s1_q.rx >= W8) && (s1_q.rx < W38)) ||
                          ((s1_q.rx >= W58) && (s1_q.rx < W78));
                eye_col = (s1_q.st == RIGHT1) ? (s1_q.rx >= W78) : (s1_q.rx < W8);
            end
            default: begin
                leg_col = (s1_q.rx >= W38) && (s1_q.rx < W58);
                eye_col = (s1_q.st == RIGHT2) ? (s1_q.rx >= W78) : (s1_q.rx < W8);
            end
        endcase
        s2_d = s1_q.pix;
        if (s1_q.in_box && !s1_q.pix.hblnk && !s1_q.pix.vblnk) begin
            if (eye_row && eye_col)
                s2_d.rgb = EYE_RGB;
            else if (body || leg_col)
                s2_d.rgb = BODY_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            mv_l_q       <= 1'b0;
            mv_r_q       <= 1'b0;
            state_q      <= IDLE;
            div_q        <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
        end else begin
            vblnk_prev_q <= vga_in.vblnk;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            mv_l_q       <= mv_l_d;
            mv_r_q       <= mv_r_d;
            state_q      <= state_d;
            div_q        <= div_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
        end
    end

    assign vga_out.vcount = s2_q.vcount;
    assign vga_out.hcount = s2_q.hcount;
    assign vga_out.vsync  = s2_q.vsync;
    assign vga_out.hsync  = s2_q.hsync;
    assign vga_out.vblnk  = s2_q.vblnk;
    assign vga_out.hblnk  = s2_q.hblnk;
    assign vga_out.rgb    = s2_q.rgb;
    assign state_o        = state_q;
endmodule
